// File: rtl/id_ex_stage_if.sv
// Decode-to-execute handshake bundle for the id_ex_stage.
// The master drives decode fields and ex_ready; the slave is the stage.
interface id_ex_stage_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [RA_W-1:0] in_rs1_addr;
    logic [RA_W-1:0] in_rs2_addr;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;
    logic [RA_W-1:0] in_rd_addr;
    logic [XLEN-1:0] in_imm;
    logic [6:0]      in_opcode;
    logic [2:0]      in_funct3;
    logic            in_funct7b5;
    logic            ex_ready;
    logic            out_valid;
    logic [XLEN-1:0] out_d1;
    logic [XLEN-1:0] out_d2;
    logic [3:0]      out_control;
    logic [RA_W-1:0] out_rd_addr;
    logic [XLEN-1:0] out_pc;
    logic            out_is_load;
    logic            out_illegal;

    modport master (
        output in_valid, in_pc,
        output in_rs1_addr, in_rs2_addr,
        output in_rs1_data, in_rs2_data,
        output in_rd_addr, in_imm,
        output in_opcode, in_funct3,
        output in_funct7b5, ex_ready,
        input  in_ready, out_valid,
        input  out_d1, out_d2,
        input  out_control, out_rd_addr,
        input  out_pc, out_is_load,
        input  out_illegal
    );

    modport slave (
        input  in_valid, in_pc,
        input  in_rs1_addr, in_rs2_addr,
        input  in_rs1_data, in_rs2_data,
        input  in_rd_addr, in_imm,
        input  in_opcode, in_funct3,
        input  in_funct7b5, ex_ready,
        output in_ready, out_valid,
        output out_d1, out_d2,
        output out_control, out_rd_addr,
        output out_pc, out_is_load,
        output out_illegal
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: ALU control decode, operand select,
// MEM/WB forwarding and load-use stall ahead of the execute ALU.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    id_ex_stage_if.slave    bus,
    input  logic            flush,
    input  logic            mem_wr_en,
    input  logic            mem_is_load,
    input  logic [RA_W-1:0] mem_rd_addr,
    input  logic [XLEN-1:0] mem_result,
    input  logic            wb_wr_en,
    input  logic [RA_W-1:0] wb_rd_addr,
    input  logic [XLEN-1:0] wb_data
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    localparam logic [1:0] SEL_RS   = 2'd0;
    localparam logic [1:0] SEL_PC   = 2'd1;
    localparam logic [1:0] SEL_ZERO = 2'd2;
    localparam logic [1:0] SEL_IMM  = 2'd1;
    localparam logic [1:0] SEL_FOUR = 2'd2;

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [RA_W-1:0] rs1_q, rs1_d;
    logic [RA_W-1:0] rs2_q, rs2_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;
    logic [RA_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [3:0]      ctrl_q, ctrl_d;
    logic [1:0]      d1sel_q, d1sel_d;
    logic [1:0]      d2sel_q, d2sel_d;
    logic            use1_q, use1_d;
    logic            use2_q, use2_d;
    logic            load_q, load_d;
    logic            ill_q, ill_d;

    logic [3:0] dec_ctrl;
    logic [1:0] dec_d1sel;
    logic [1:0] dec_d2sel;
    logic       dec_use1;
    logic       dec_use2;
    logic       dec_load;
    logic       dec_ill;

    logic            stall;
    logic            out_valid;
    logic            in_ready;
    logic            fire_in;
    logic            fire_out;
    logic            hz1;
    logic            hz2;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;
    logic [XLEN-1:0] d1;
    logic [XLEN-1:0] d2;

    function automatic logic [3:0] alu_f3(
        input logic [2:0] f3,
        input logic       alt
    );
        logic [3:0] c;
        c = ALU_ADD;
        unique case (f3)
            3'b000: c = alt ? ALU_SUB : ALU_ADD;
            3'b001: c = ALU_SLL;
            3'b010: c = ALU_SLT;
            3'b011: c = ALU_SLTU;
            3'b100: c = ALU_XOR;
            3'b101: c = alt ? ALU_SRA : ALU_SRL;
            3'b110: c = ALU_OR;
            3'b111: c = ALU_AND;
        endcase
        return c;
    endfunction

    // x0 is hard zero; a MEM load has no result yet, so only ALU results forward
    function automatic logic [XLEN-1:0] fwd(
        input logic [RA_W-1:0] a,
        input logic [XLEN-1:0] held,
        input logic            mwe,
        input logic            mld,
        input logic [RA_W-1:0] mrd,
        input logic [XLEN-1:0] mres,
        input logic            wwe,
        input logic [RA_W-1:0] wrd,
        input logic [XLEN-1:0] wd
    );
        logic [XLEN-1:0] r;
        r = held;
        if (a == '0)
            r = '0;
        else if (mwe && !mld && (mrd == a))
            r = mres;
        else if (wwe && (wrd == a))
            r = wd;
        return r;
    endfunction

    always_comb begin
        dec_ctrl  = ALU_ADD;
        dec_d1sel = SEL_RS;
        dec_d2sel = SEL_RS;
        dec_use1  = 1'b0;
        dec_use2  = 1'b0;
        dec_load  = 1'b0;
        dec_ill   = 1'b0;
        unique case (1'b1)
            (bus.in_opcode == OPC_OP): begin
                dec_ctrl = alu_f3(bus.in_funct3, bus.in_funct7b5);
                dec_use1 = 1'b1;
                dec_use2 = 1'b1;
            end
            (bus.in_opcode == OPC_IMM): begin
                dec_ctrl = alu_f3(bus.in_funct3,
                    bus.in_funct7b5 && (bus.in_funct3 == 3'b101));
                dec_d2sel = SEL_IMM;
                dec_use1  = 1'b1;
            end
            (bus.in_opcode == OPC_LOAD): begin
                dec_d2sel = SEL_IMM;
                dec_use1  = 1'b1;
                dec_load  = 1'b1;
            end
            (bus.in_opcode == OPC_STORE): begin
                dec_d2sel = SEL_IMM;
                dec_use1  = 1'b1;
                dec_use2  = 1'b1;
            end
            (bus.in_opcode == OPC_BRANCH): begin
                unique case (bus.in_funct3[2:1])
                    2'b10:   dec_ctrl = ALU_SLT;
                    2'b11:   dec_ctrl = ALU_SLTU;
                    default: dec_ctrl = ALU_SUB;
                endcase
                dec_use1 = 1'b1;
                dec_use2 = 1'b1;
            end
            (bus.in_opcode == OPC_JALR): begin
                dec_d2sel = SEL_IMM;
                dec_use1  = 1'b1;
            end
            (bus.in_opcode == OPC_JAL): begin
                dec_d1sel = SEL_PC;
                dec_d2sel = SEL_FOUR;
            end
            (bus.in_opcode == OPC_LUI): begin
                dec_d1sel = SEL_ZERO;
                dec_d2sel = SEL_IMM;
            end
            (bus.in_opcode == OPC_AUIPC): begin
                dec_d1sel = SEL_PC;
                dec_d2sel = SEL_IMM;
            end
            default: dec_ill = 1'b1;
        endcase
    end

    always_comb begin
        hz1 = use1_q && (rs1_q != '0) && (rs1_q == mem_rd_addr);
        hz2 = use2_q && (rs2_q != '0) && (rs2_q == mem_rd_addr);
        stall = valid_q && mem_wr_en && mem_is_load && (hz1 || hz2);
        out_valid = valid_q && !stall;
        fire_out  = out_valid && bus.ex_ready;
        in_ready  = !valid_q || fire_out;
        fire_in   = bus.in_valid && in_ready;
    end

    always_comb begin
        rs1_fwd = fwd(rs1_q, rs1_data_q, mem_wr_en, mem_is_load,
                      mem_rd_addr, mem_result, wb_wr_en,
                      wb_rd_addr, wb_data);
        rs2_fwd = fwd(rs2_q, rs2_data_q, mem_wr_en, mem_is_load,
                      mem_rd_addr, mem_result, wb_wr_en,
                      wb_rd_addr, wb_data);
    end

    always_comb begin
        d1 = rs1_fwd;
        d2 = rs2_fwd;
        unique case (d1sel_q)
            SEL_PC:   d1 = pc_q;
            SEL_ZERO: d1 = '0;
            default:  d1 = rs1_fwd;
        endcase
        unique case (d2sel_q)
            SEL_IMM:  d2 = imm_q;
            SEL_FOUR: d2 = XLEN'(4);
            default:  d2 = rs2_fwd;
        endcase
    end

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        rd_d       = rd_q;
        imm_d      = imm_q;
        ctrl_d     = ctrl_q;
        d1sel_d    = d1sel_q;
        d2sel_d    = d2sel_q;
        use1_d     = use1_q;
        use2_d     = use2_q;
        load_d     = load_q;
        ill_d      = ill_q;
        // a held instruction must not miss a WB write while it waits
        if (valid_q && !fire_out && wb_wr_en && (wb_rd_addr != '0)) begin
            if (wb_rd_addr == rs1_q) rs1_data_d = wb_data;
            if (wb_rd_addr == rs2_q) rs2_data_d = wb_data;
        end
        if (flush) begin
            valid_d = 1'b0;
        end else if (fire_in) begin
            valid_d    = 1'b1;
            pc_d       = bus.in_pc;
            rs1_d      = bus.in_rs1_addr;
            rs2_d      = bus.in_rs2_addr;
            rd_d       = bus.in_rd_addr;
            imm_d      = bus.in_imm;
            ctrl_d     = dec_ctrl;
            d1sel_d    = dec_d1sel;
            d2sel_d    = dec_d2sel;
            use1_d     = dec_use1;
            use2_d     = dec_use2;
            load_d     = dec_load;
            ill_d      = dec_ill;
            rs1_data_d = (wb_wr_en && (wb_rd_addr == bus.in_rs1_addr))
                       ? wb_data : bus.in_rs1_data;
            rs2_data_d = (wb_wr_en && (wb_rd_addr == bus.in_rs2_addr))
                       ? wb_data : bus.in_rs2_data;
        end else if (fire_out) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            rd_q       <= '0;
            imm_q      <= '0;
            ctrl_q     <= ALU_ADD;
            d1sel_q    <= SEL_RS;
            d2sel_q    <= SEL_RS;
            use1_q     <= 1'b0;
            use2_q     <= 1'b0;
            load_q     <= 1'b0;
            ill_q      <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            rd_q       <= rd_d;
            imm_q      <= imm_d;
            ctrl_q     <= ctrl_d;
            d1sel_q    <= d1sel_d;
            d2sel_q    <= d2sel_d;
            use1_q     <= use1_d;
            use2_q     <= use2_d;
            load_q     <= load_d;
            ill_q      <= ill_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_d1      = d1;
    assign bus.out_d2      = d2;
    assign bus.out_control = ctrl_q;
    assign bus.out_rd_addr = rd_q;
    assign bus.out_pc      = pc_q;
    assign bus.out_is_load = load_q;
    assign bus.out_illegal = ill_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register and operand-select stage directly upstream of the execute-stage ALU.
- Captures decoded instruction fields from decode and generates the 4-bit ALU control code.
- Selects ALU operand sources (register, immediate, PC, zero) and forwards results from the MEM and WB stages.
- Detects load-use hazards and presents d1/d2/control to the ALU with a valid/ready handshake.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  decode offers an instruction
in_ready  out  1  stage can accept
in_pc  in  XLEN  instruction PC
in_rs1_addr, in_rs2_addr  in  RA_W  source registers
in_rs1_data, in_rs2_data  in  XLEN  regfile read data
in_rd_addr  in  RA_W  destination register
in_imm  in  XLEN  sign-extended immediate
in_opcode  in  7  opcode[6:0]
in_funct3  in  3  funct3
in_funct7b5  in  1  instr[30]
flush  in  1  kill held and incoming instruction
ex_ready  in  1  execute accepts current output
mem_wr_en, mem_is_load  in  1 each  MEM-stage write enable, MEM holds a load
mem_rd_addr  in  RA_W  MEM-stage destination
mem_result  in  XLEN  MEM-stage ALU result
wb_wr_en  in  1  WB write enable
wb_rd_addr  in  RA_W  WB destination
wb_data  in  XLEN  WB write data
out_valid  out  1  d1/d2/control valid for ALU
out_d1, out_d2  out  XLEN  ALU operands
out_control  out  4  ALU op code
out_rd_addr  out  RA_W  destination
out_pc  out  XLEN  held PC
out_is_load, out_illegal  out  1 each  held instr is a load / unknown opcode

Behaviour:
- Reset: all held registers cleared. out_valid=0, out_control=4'b0000, out_d1=out_d2=0, out_rd_addr=0, out_pc=0, out_is_load=0, out_illegal=0. in_ready=1 from the first cycle after reset.
- Handshake:
  - fire_in = in_valid & in_ready.
  - fire_out = out_valid & ex_ready.
  - in_ready = !held_valid | fire_out.
  - out_valid = held_valid & !stall.
  - Latency: 1 cycle from fire_in to out_valid.
- Control decode at capture; codes: ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB 1000, SRA 1101.
  - OP (0110011): from funct3. funct7b5 selects SUB for funct3=000 and SRA for funct3=101.
  - OP-IMM (0010011): same mapping, but funct7b5 is honoured only for funct3=101 (SRAI). ADDI never yields SUB.
  - LOAD/STORE/JALR/JAL/LUI/AUIPC: ADD.
  - BRANCH: BEQ/BNE→SUB, BLT/BGE→SLT, BLTU/BGEU→SLTU.
  - Any other opcode: ADD with out_illegal=1.
- Operand select:
  - d1: zero for LUI; PC for AUIPC/JAL; else forwarded rs1.
  - d2: imm for OP-IMM/LOAD/STORE/LUI/AUIPC/JALR; 4 for JAL; else forwarded rs2.
- Forwarding (combinational on held state; register address 0 never matches and always yields 0):
  - MEM match (mem_wr_en & !mem_is_load & addr equal) → mem_result.
  - else WB match → wb_data.
  - else held data.
  - MEM has priority over WB.
- Load-use stall: held_valid and a used rs equals mem_rd_addr (nonzero) with mem_wr_en & mem_is_load.
  - out_valid=0 and in_ready=0; the held instruction is not consumed.
- Operand refresh: each cycle held_valid & !fire_out, if wb_wr_en and wb_rd_addr equals a held rs (nonzero), latch wb_data into the held rs data. This keeps operands correct across multi-cycle stalls or ex_ready=0.
- Capture: on fire_in, held fields are loaded. If decode's rs matches wb_rd_addr with wb_wr_en the same cycle, wb_data is captured (regfile write-read bypass).
- flush: next cycle held_valid=0. Any same-cycle fire_in is discarded. flush overrides stall and capture.
- Simultaneous fire_out & fire_in: new instruction replaces the old one with no bubble.
- rst mid-stall or mid-handshake: state cleared exactly as at reset; no output pulses.

Test Plan:
- ADD x3,x1,x2 with rs1=5, rs2=7, ex_ready=1 → next cycle out_valid=1, d1=5, d2=7, control=0000. SUB (funct7b5=1) → control=1000. SRAI imm=3 → control=1101, d2=3.
- Back-to-back: mem_wr_en=1, mem_rd_addr=1, mem_result=0x10, and wb_wr_en=1, wb_rd_addr=1, wb_data=0x20 → d1=0x10 (MEM priority). With MEM match removed → d1=0x20. rs1=x0 with mem_rd_addr=0 → d1=0.
- Load-use: held ADD uses x4, mem_is_load=1, mem_rd_addr=4 → out_valid=0, in_ready=0 for 1 cycle. Next cycle wb_rd_addr=4, wb_data=0xAB → out_valid=1, d1=0xAB.
- ex_ready=0 for 3 cycles while WB writes x2=0x99 in cycle 2 → held rs2 refreshed. When ex_ready rises, d2=0x99. in_ready=0 throughout.
- BLTU → control=0011. LUI imm=0x12345000 → d1=0, d2=0x12345000, control=0000. Opcode 1111111 → out_illegal=1, control=0000.
- flush asserted with in_valid=1 while holding a valid instruction → next cycle out_valid=0 and the incoming instruction is never presented. rst asserted mid-stall → all outputs at reset values next cycle.
